// File: rtl/ext_interrupt_generator.sv
// ext_interrupt_generator
// Shapes single-cycle event strobes into an external interrupt line. Each
// pulse is held active for PULSE_CYCLES clocks and followed by at least
// GAP_CYCLES inactive clocks. Events arriving while a pulse or gap is in
// progress are queued in a saturating pending counter.
// Optional build macro EXT_INT_GENERATOR_LEVEL_ACK_EN: the pulse is also held
// until an acknowledge has been seen on i_ack (level-interrupt emulation).
module ext_interrupt_generator #(
  parameter int unsigned PULSE_CYCLES = 40,
  parameter int unsigned GAP_CYCLES   = 40,
  parameter int unsigned PEND_BITS    = 4,
  parameter bit          ACTIVE_HIGH  = 1'b1
) (
  input  logic                 i_clk_20mhz,
  input  logic                 i_rstn_20mhz,
  input  logic                 i_event,
  input  logic                 i_ack,
  input  logic                 i_clr_overflow,
  output logic                 eo_interrupt,
  output logic                 o_busy,
  output logic [PEND_BITS-1:0] o_pending,
  output logic                 o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [7:0]           PULSE_LAST = 8'(PULSE_CYCLES - 32'd1);
  localparam logic [7:0]           GAP_LAST   = 8'(GAP_CYCLES - 32'd1);
  localparam logic [7:0]           TIMER_MAX  = 8'hFF;
  localparam logic [7:0]           TIMER_ZERO = 8'h00;
  localparam logic [7:0]           TIMER_ONE  = 8'h01;
  localparam logic [PEND_BITS-1:0] PEND_MAX   = {PEND_BITS{1'b1}};
  localparam logic [PEND_BITS-1:0] PEND_ZERO  = {PEND_BITS{1'b0}};
  localparam logic [PEND_BITS-1:0] PEND_ONE   = PEND_BITS'(1'b1);
  localparam logic                 LINE_ON    = ACTIVE_HIGH;
  localparam logic                 LINE_OFF   = ~ACTIVE_HIGH;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [7:0]             timer_r;
  logic [PEND_BITS-1:0]   pend_r;
  logic [PEND_BITS-1:0]   pend_next_s;
  logic                   ovf_r;
  logic                   ovf_next_s;
  logic                   ovf_set_s;
  logic                   enter_assert_s;
  logic                   pulse_done_s;
  logic                   line_r;
  logic                   busy_r;

`ifdef EXT_INT_GENERATOR_LEVEL_ACK_EN
  logic ack_seen_r;

  // The pulse may end once its minimum width is met and an ack was seen,
  // counting an ack that arrives in the exit clock itself.
  assign pulse_done_s = (timer_r >= PULSE_LAST) && (ack_seen_r || i_ack);

  // Remembers any ack during the current pulse; cleared on each new pulse.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      ack_seen_r <= 1'b0;
    end else if (enter_assert_s) begin
      ack_seen_r <= 1'b0;
    end else if ((state_r == ST_ASSERT) && i_ack) begin
      ack_seen_r <= 1'b1;
    end else begin
      ack_seen_r <= ack_seen_r;
    end
  end
`else
  logic unused_ack_s;

  // Purely timed pulse; the acknowledge input is not connected to any logic.
  assign pulse_done_s = (timer_r == PULSE_LAST);
  assign unused_ack_s = i_ack;
`endif

  // Next-state decode for the pulse/gap sequencer.
  always_comb begin
    next_state_s   = state_r;
    enter_assert_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_r != PEND_ZERO) begin
          next_state_s = ST_ASSERT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (pulse_done_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_ASSERT;
        end
      end
      ST_GAP: begin
        if (timer_r == GAP_LAST) begin
          if (pend_r != PEND_ZERO) begin
            next_state_s = ST_ASSERT;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    if ((next_state_s == ST_ASSERT) && (state_r != ST_ASSERT)) begin
      enter_assert_s = 1'b1;
    end else begin
      enter_assert_s = 1'b0;
    end
  end

  // Pending queue: one event in per strobe, one out per pulse start; a full
  // queue drops the event and raises the sticky overflow flag.
  always_comb begin
    pend_next_s = pend_r;
    ovf_set_s   = 1'b0;
    if (i_event && !enter_assert_s) begin
      if (pend_r == PEND_MAX) begin
        pend_next_s = pend_r;
        ovf_set_s   = 1'b1;
      end else begin
        pend_next_s = pend_r + PEND_ONE;
      end
    end else if (!i_event && enter_assert_s) begin
      pend_next_s = pend_r - PEND_ONE;
    end else begin
      pend_next_s = pend_r;
    end
    // A new overflow in the same clock as a clear keeps the flag set.
    if (ovf_set_s) begin
      ovf_next_s = 1'b1;
    end else if (i_clr_overflow) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // State register and phase timer; the timer restarts on every state change.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_r <= ST_IDLE;
      timer_r <= TIMER_ZERO;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        timer_r <= TIMER_ZERO;
      end else if (timer_r != TIMER_MAX) begin
        timer_r <= timer_r + TIMER_ONE;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Pending count and sticky overflow flag.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      pend_r <= PEND_ZERO;
      ovf_r  <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      ovf_r  <= ovf_next_s;
    end
  end

  // Line and busy are registered from the next state so they move together
  // with the state register; reset forces the inactive level at once.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      line_r <= LINE_OFF;
      busy_r <= 1'b0;
    end else begin
      line_r <= (next_state_s == ST_ASSERT) ? LINE_ON : LINE_OFF;
      busy_r <= (next_state_s != ST_IDLE);
    end
  end

  assign eo_interrupt = line_r;
  assign o_busy       = busy_r;
  assign o_pending    = pend_r;
  assign o_overflow   = ovf_r;

endmodule

// File: tb/tb_ext_interrupt_generator.sv
// Testbench for ext_interrupt_generator (default parameters plus an
// ACTIVE_HIGH=0 instance sharing the same inputs). The reference model is a
// pulse schedule: a pulse may start at the first edge where the queue is
// non-empty and the previous pulse+gap window has elapsed.
module tb_ext_interrupt_generator;

  localparam int P      = 40;
  localparam int G      = 40;
  localparam int PEND_W = 4;
  localparam int PMAX   = 15;

  logic              i_clk_20mhz;
  logic              i_rstn_20mhz;
  logic              i_event;
  logic              i_ack;
  logic              i_clr_overflow;
  logic              eo_interrupt;
  logic              o_busy;
  logic [PEND_W-1:0] o_pending;
  logic              o_overflow;
  logic              lo_interrupt;
  logic              lo_busy;
  logic [PEND_W-1:0] lo_pending;
  logic              lo_overflow;

  int n_cmp;
  int n_err;

  // Reference model state
  int   n_edge;
  int   m_pend;
  int   m_s;
  int   m_ready;
  logic m_has;
  logic m_ovf;
  logic m_line;
  logic m_busy;

  ext_interrupt_generator dut (
    .i_clk_20mhz    (i_clk_20mhz),
    .i_rstn_20mhz   (i_rstn_20mhz),
    .i_event        (i_event),
    .i_ack          (i_ack),
    .i_clr_overflow (i_clr_overflow),
    .eo_interrupt   (eo_interrupt),
    .o_busy         (o_busy),
    .o_pending      (o_pending),
    .o_overflow     (o_overflow)
  );

  ext_interrupt_generator #(.ACTIVE_HIGH(1'b0)) dut_low (
    .i_clk_20mhz    (i_clk_20mhz),
    .i_rstn_20mhz   (i_rstn_20mhz),
    .i_event        (i_event),
    .i_ack          (i_ack),
    .i_clr_overflow (i_clr_overflow),
    .eo_interrupt   (lo_interrupt),
    .o_busy         (lo_busy),
    .o_pending      (lo_pending),
    .o_overflow     (lo_overflow)
  );

  // 20 MHz clock
  initial begin
    i_clk_20mhz = 1'b0;
    forever #25 i_clk_20mhz = ~i_clk_20mhz;
  end

  task automatic model_reset();
    m_pend  = 0;
    m_s     = 0;
    m_ready = 0;
    m_has   = 1'b0;
    m_ovf   = 1'b0;
    m_line  = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge(input logic ev, input logic clr);
    logic start;
    logic ovf_set;
    n_edge++;
    start   = (m_pend > 0) && (n_edge >= m_ready);
    ovf_set = 1'b0;
    if (start) begin
      m_s     = n_edge;
      m_ready = n_edge + P + G;
      m_has   = 1'b1;
    end
    if (ev && !start) begin
      if (m_pend == PMAX) ovf_set = 1'b1;
      else m_pend++;
    end else if (!ev && start) begin
      m_pend--;
    end
    m_ovf  = ovf_set | (m_ovf & ~clr);
    m_line = m_has && (n_edge >= m_s) && (n_edge < m_s + P);
    m_busy = m_has && (n_edge >= m_s) && (n_edge < m_s + P + G);
  endtask

  // One model-tracked clock: drive inputs, take the edge, sample 1 ns later.
  task automatic tick(input logic ev, input logic clr);
    i_event        = ev;
    i_clr_overflow = clr;
`ifdef EXT_INT_GENERATOR_LEVEL_ACK_EN
    i_ack          = 1'b1;
`else
    i_ack          = 1'($urandom_range(0, 1));
`endif
    @(posedge i_clk_20mhz);
    model_edge(ev, clr);
    #1;
  endtask

  task automatic do_reset();
    i_rstn_20mhz   = 1'b0;
    i_event        = 1'b0;
    i_ack          = 1'b0;
    i_clr_overflow = 1'b0;
    repeat (3) @(posedge i_clk_20mhz);
    #1;
    i_rstn_20mhz = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (eo_interrupt !== 1'b0 || lo_interrupt !== 1'b1 || o_busy !== 1'b0 ||
        o_pending !== 4'd0 || o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got line=%b lo=%b busy=%b pend=%0d ovf=%b, want 0 1 0 0 0",
               eo_interrupt, lo_interrupt, o_busy, o_pending, o_overflow);
    end
  endtask

  task automatic test_single_event();
    int act_cnt;
    int low_cnt;
    int busy_cnt;
    act_cnt  = 0;
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (9) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_cmp++;
    if (o_pending !== 4'd1 || eo_interrupt !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency1: got pend=%0d line=%b, want 1 0", o_pending, eo_interrupt);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0);
      if (i == 0) begin
        n_cmp++;
        if (o_pending !== 4'd0 || eo_interrupt !== 1'b1 || o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_latency2: got pend=%0d line=%b busy=%b, want 0 1 1",
                   o_pending, eo_interrupt, o_busy);
        end
      end
      n_cmp++;
      if (eo_interrupt !== m_line || lo_interrupt !== ~m_line || o_busy !== m_busy ||
          o_pending !== PEND_W'(m_pend) || o_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL single_model i=%0d: got line=%b lo=%b busy=%b pend=%0d ovf=%b, want %b %b %b %0d %b",
                 i, eo_interrupt, lo_interrupt, o_busy, o_pending, o_overflow,
                 m_line, ~m_line, m_busy, m_pend, m_ovf);
      end
      if (eo_interrupt) act_cnt++;
      if (!lo_interrupt) low_cnt++;
      if (o_busy) busy_cnt++;
    end
    n_cmp++;
    if (act_cnt != P || low_cnt != P || busy_cnt != P + G) begin
      n_err++;
      $display("FAIL single_width: got active=%0d low_active=%0d busy=%0d, want %0d %0d %0d",
               act_cnt, low_cnt, busy_cnt, P, P, P + G);
    end
  endtask

  task automatic test_back_to_back();
    int exp_pend[3];
    int pulses;
    int act_cnt;
    logic prev;
    exp_pend = '{1, 1, 2};
    pulses   = 0;
    act_cnt  = 0;
    prev     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if (o_pending !== PEND_W'(exp_pend[i])) begin
        n_err++;
        $display("FAIL b2b_pending i=%0d: got %0d, want %0d", i, o_pending, exp_pend[i]);
      end
      if (eo_interrupt && !prev) pulses++;
      if (eo_interrupt) act_cnt++;
      prev = eo_interrupt;
    end
    for (int i = 0; i < 260; i++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if (eo_interrupt !== m_line || o_busy !== m_busy || o_pending !== PEND_W'(m_pend)) begin
        n_err++;
        $display("FAIL b2b_model i=%0d: got line=%b busy=%b pend=%0d, want %b %b %0d",
                 i, eo_interrupt, o_busy, o_pending, m_line, m_busy, m_pend);
      end
      if (eo_interrupt && !prev) pulses++;
      if (eo_interrupt) act_cnt++;
      prev = eo_interrupt;
    end
    n_cmp++;
    if (pulses != 3 || act_cnt != 3 * P || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: got pulses=%0d active=%0d busy=%b, want 3 %0d 0",
               pulses, act_cnt, o_busy, 3 * P);
    end
  endtask

  task automatic test_overflow();
    int pulses;
    int budget;
    logic prev;
    logic ev;
    logic clr;
    pulses = 0;
    prev   = 1'b0;
    for (int i = 0; i < 22; i++) begin
      ev  = (i <= 20);
      clr = (i >= 20);
      tick(ev, clr);
      if (eo_interrupt && !prev) pulses++;
      prev = eo_interrupt;
      if (i == 19) begin
        n_cmp++;
        if (o_pending !== 4'd15 || o_overflow !== 1'b1) begin
          n_err++;
          $display("FAIL ovf_saturate: got pend=%0d ovf=%b, want 15 1", o_pending, o_overflow);
        end
      end
      if (i == 20) begin
        n_cmp++;
        if (o_overflow !== 1'b1 || o_pending !== 4'd15) begin
          n_err++;
          $display("FAIL ovf_set_wins: got ovf=%b pend=%0d, want 1 15", o_overflow, o_pending);
        end
      end
      if (i == 21) begin
        n_cmp++;
        if (o_overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_clear: got ovf=%b, want 0", o_overflow);
        end
      end
    end
    budget = 0;
    while ((m_busy || m_pend != 0 || o_busy) && budget < 2000) begin
      tick(1'b0, 1'b0);
      budget++;
      n_cmp++;
      if (eo_interrupt !== m_line || o_busy !== m_busy ||
          o_pending !== PEND_W'(m_pend) || o_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL ovf_model: got line=%b busy=%b pend=%0d ovf=%b, want %b %b %0d %b",
                 eo_interrupt, o_busy, o_pending, o_overflow, m_line, m_busy, m_pend, m_ovf);
      end
      if (eo_interrupt && !prev) pulses++;
      prev = eo_interrupt;
    end
    n_cmp++;
    if (pulses != 16 || budget >= 2000) begin
      n_err++;
      $display("FAIL ovf_pulses: got pulses=%0d drain_cycles=%0d, want 16 pulses within 2000",
               pulses, budget);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int act_cnt;
    act_cnt = 0;
    for (int i = 0; i < 21; i++) tick(i < 4, 1'b0);
    n_cmp++;
    if (o_pending !== 4'd3 || eo_interrupt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: got pend=%0d line=%b, want 3 1", o_pending, eo_interrupt);
    end
    #3;
    i_rstn_20mhz = 1'b0;
    #2;
    n_cmp++;
    if (eo_interrupt !== 1'b0 || lo_interrupt !== 1'b1 || o_pending !== 4'd0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got line=%b lo=%b pend=%0d busy=%b, want 0 1 0 0",
               eo_interrupt, lo_interrupt, o_pending, o_busy);
    end
    repeat (2) @(posedge i_clk_20mhz);
    #1;
    i_rstn_20mhz = 1'b1;
    model_reset();
    for (int i = 0; i < 150; i++) begin
      tick(1'b0, 1'b0);
      if (eo_interrupt !== 1'b0 || o_busy !== 1'b0) act_cnt++;
    end
    n_cmp++;
    if (act_cnt != 0 || o_pending !== 4'd0) begin
      n_err++;
      $display("FAIL rst_no_pulse: got active_or_busy_cycles=%0d pend=%0d, want 0 0",
               act_cnt, o_pending);
    end
  endtask

  task automatic test_random();
    int thr;
    int len;
    int budget;
    logic ev;
    logic clr;
    for (int r = 0; r < 6; r++) begin
      thr = $urandom_range(1, 8);
      len = $urandom_range(30, 200);
      for (int i = 0; i < len; i++) begin
        ev  = ($urandom_range(0, 9) < thr);
        clr = ($urandom_range(0, 15) == 0);
        tick(ev, clr);
        n_cmp++;
        if (eo_interrupt !== m_line || lo_interrupt !== ~m_line || o_busy !== m_busy ||
            o_pending !== PEND_W'(m_pend) || o_overflow !== m_ovf) begin
          n_err++;
          $display("FAIL random r=%0d i=%0d: got line=%b lo=%b busy=%b pend=%0d ovf=%b, want %b %b %b %0d %b",
                   r, i, eo_interrupt, lo_interrupt, o_busy, o_pending, o_overflow,
                   m_line, ~m_line, m_busy, m_pend, m_ovf);
        end
      end
    end
    budget = 0;
    while ((m_busy || m_pend != 0) && budget < 2000) begin
      tick(1'b0, 1'b1);
      budget++;
      n_cmp++;
      if (eo_interrupt !== m_line || o_busy !== m_busy ||
          o_pending !== PEND_W'(m_pend) || o_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL random_drain: got line=%b busy=%b pend=%0d ovf=%b, want %b %b %0d %b",
                 eo_interrupt, o_busy, o_pending, o_overflow, m_line, m_busy, m_pend, m_ovf);
      end
    end
    n_cmp++;
    if (budget >= 2000 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL random_timeout: got busy=%b after %0d drain cycles, want idle", o_busy, budget);
    end
  endtask

`ifdef EXT_INT_GENERATOR_LEVEL_ACK_EN
  task automatic raw_tick(input logic ev, input logic ack);
    i_event        = ev;
    i_ack          = ack;
    i_clr_overflow = 1'b0;
    @(posedge i_clk_20mhz);
    #1;
  endtask

  task automatic test_level_ack();
    int ack_at[3];
    int exp_len[3];
    int cnt;
    int budget;
    ack_at  = '{210, 5, 100};
    exp_len = '{210, 40, 100};
    for (int k = 0; k < 3; k++) begin
      raw_tick(1'b1, 1'b0);
      raw_tick(1'b0, 1'b0);
      cnt    = eo_interrupt ? 1 : 0;
      budget = 0;
      while (eo_interrupt && budget < 400) begin
        raw_tick(1'b0, cnt == ack_at[k]);
        budget++;
        if (eo_interrupt) cnt++;
      end
      n_cmp++;
      if (cnt != exp_len[k]) begin
        n_err++;
        $display("FAIL level_ack k=%0d: got active=%0d, want %0d", k, cnt, exp_len[k]);
      end
      repeat (G + 2) raw_tick(1'b0, 1'b0);
      n_cmp++;
      if (o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL level_idle k=%0d: got busy=%b, want 0", k, o_busy);
      end
    end
    do_reset();
  endtask
`endif

  // Test sequence
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    n_edge = 0;
    model_reset();
    test_reset();
    test_single_event();
    test_back_to_back();
    test_overflow();
    test_reset_mid_pulse();
    test_random();
`ifdef EXT_INT_GENERATOR_LEVEL_ACK_EN
    test_level_ack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
